// File: rtl/div.sv
// Sequential restoring signed divider that produces one quotient bit per clock.
// The quotient truncates toward zero and the remainder takes the sign of the dividend.
module div #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] op_a_i,
  input  logic [DIVISOR_W-1:0]  op_b_i,
  output logic                  ready_o,
  output logic [DIVIDEND_W-1:0] quot_o,
  output logic [DIVISOR_W-1:0]  rem_o,
  output logic                  dbz_o
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            r_state;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W:0]    r_r;
  logic [DIVISOR_W-1:0]  r_b;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_dbz;

  logic [DIVIDEND_W-1:0] w_a_mag;
  logic [DIVISOR_W-1:0]  w_b_mag;
  logic [DIVISOR_W:0]    w_t;
  logic [DIVISOR_W:0]    w_sub;
  logic                  w_ge;
  logic                  w_b_zero;
  logic                  w_last;
  logic [DIVIDEND_W-1:0] w_quot_neg;
  logic [DIVISOR_W-1:0]  w_rem_neg;
  logic                  w_unused;

  // Magnitudes are unsigned, so the most-negative operands are representable.
  assign w_a_mag  = op_a_i[DIVIDEND_W-1] ? (~op_a_i + DIVIDEND_W'(1)) : op_a_i;
  assign w_b_mag  = op_b_i[DIVISOR_W-1]  ? (~op_b_i + DIVISOR_W'(1))  : op_b_i;
  assign w_b_zero = (op_b_i == '0);

  assign w_t    = {r_r[DIVISOR_W-1:0], r_q[DIVIDEND_W-1]};
  assign w_ge   = (w_t >= {1'b0, r_b});
  assign w_sub  = w_t - {1'b0, r_b};
  assign w_last = (r_cnt == CNT_W'(DIVIDEND_W - 1));

  // The partial remainder always ends a step below |b|, so its top bit stays clear.
  assign w_unused = r_r[DIVISOR_W];

  assign w_quot_neg = ~r_q + DIVIDEND_W'(1);
  assign w_rem_neg  = ~r_r[DIVISOR_W-1:0] + DIVISOR_W'(1);

  assign ready_o = (r_state == S_IDLE);
  assign quot_o  = r_neg_q ? w_quot_neg : r_q;
  assign rem_o   = r_neg_r ? w_rem_neg : r_r[DIVISOR_W-1:0];
  assign dbz_o   = r_dbz;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_r   <= '0;
            r_cnt <= '0;
            if (w_b_zero) begin
              // Saturate toward the dividend's sign; signs are stored unflipped.
              r_dbz   <= 1'b1;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_q     <= op_a_i[DIVIDEND_W-1] ? {1'b1, {(DIVIDEND_W-1){1'b0}}}
                                              : {1'b0, {(DIVIDEND_W-1){1'b1}}};
            end else begin
              r_dbz   <= 1'b0;
              r_neg_q <= op_a_i[DIVIDEND_W-1] ^ op_b_i[DIVISOR_W-1];
              r_neg_r <= op_a_i[DIVIDEND_W-1];
              r_q     <= w_a_mag;
              r_b     <= w_b_mag;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_r   <= w_ge ? w_sub : w_t;
          r_q   <= {r_q[DIVIDEND_W-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed-vector and randomised checks for the restoring signed divider.
module tb_div;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [23:0] op_a_i;
  logic [15:0] op_b_i;
  logic        ready_o;
  logic [23:0] quot_o;
  logic [15:0] rem_o;
  logic        dbz_o;

  int checks;
  int errors;

  div #(.DIVIDEND_W(24), .DIVISOR_W(16)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_a_i  (op_a_i),
    .op_b_i  (op_b_i),
    .ready_o (ready_o),
    .quot_o  (quot_o),
    .rem_o   (rem_o),
    .dbz_o   (dbz_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [23:0] a;
    logic [15:0] b;
    logic [23:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where ready_o is high again.
  task automatic run_op(input logic [23:0] a, input logic [15:0] b, output int lat);
    int budget;
    budget = 0;
    while (!ready_o && budget < 100) begin
      @(negedge clk_i);
      budget++;
    end
    op_a_i  = a;
    op_b_i  = b;
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 0;
    while (!ready_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    if (lat >= 100) chk("timeout", lat, 24);
  endtask

  initial begin
    int lat;
    int cnt;
    logic exp_ready;
    logic [31:0] raw;
    logic signed [23:0] sa;
    logic signed [15:0] sb;
    longint aa, bb, qq, rr;

    checks  = 0;
    errors  = 0;
    start_i = 1'b0;
    op_a_i  = '0;
    op_b_i  = '0;

    vecs[0]  = '{24'd1000,     16'd7,      24'd142,     16'd6,      1'b0, 24};
    vecs[1]  = '{-24'sd1000,   16'd7,      24'hFFFF72,  16'hFFFA,   1'b0, 24};
    vecs[2]  = '{24'd1000,     -16'sd7,    24'hFFFF72,  16'd6,      1'b0, 24};
    vecs[3]  = '{-24'sd1000,   -16'sd7,    24'd142,     16'hFFFA,   1'b0, 24};
    vecs[4]  = '{24'h7FFFFF,   16'h8000,   24'hFFFF01,  16'h7FFF,   1'b0, 24};
    vecs[5]  = '{24'h800000,   16'hFFFF,   24'h800000,  16'h0000,   1'b0, 24};
    vecs[6]  = '{24'd0,        16'd5,      24'd0,       16'd0,      1'b0, 24};
    vecs[7]  = '{24'd5,        16'd0,      24'h7FFFFF,  16'd0,      1'b1, 0};
    vecs[8]  = '{-24'sd5,      16'd0,      24'h800000,  16'd0,      1'b1, 0};
    vecs[9]  = '{24'd9,        16'd3,      24'd3,       16'd0,      1'b0, 24};
    vecs[10] = '{24'd100,      16'd10,     24'd10,      16'd0,      1'b0, 24};

    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("reset_ready", ready_o, 1);
    chk("reset_quot", quot_o, 0);
    chk("reset_rem", rem_o, 0);
    chk("reset_dbz", dbz_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_quot", i), quot_o, vecs[i].q);
      chk($sformatf("vec%0d_rem", i), rem_o, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), dbz_o, vecs[i].dbz);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      $display("vec%0d: a=%0h b=%0h -> quot=%0h rem=%0h dbz=%0b lat=%0d",
               i, vecs[i].a, vecs[i].b, quot_o, rem_o, dbz_o, lat);
    end

    // A second request in the middle of RUN must be ignored.
    op_a_i  = 24'd100;
    op_b_i  = 16'd10;
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 1;
    repeat (9) begin
      @(negedge clk_i);
      lat++;
    end
    op_a_i  = 24'd77;
    op_b_i  = 16'd3;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    lat++;
    while (!ready_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    chk("busy_latency", lat - 1, 24);
    chk("busy_quot", quot_o, 10);
    chk("busy_rem", rem_o, 0);
    $display("busy: quot=%0h rem=%0h lat=%0d", quot_o, rem_o, lat - 1);

    // start_i held high: ready_o pattern is 24 low, 1 high, repeated.
    op_a_i  = 24'd100;
    op_b_i  = 16'd10;
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    cnt = 0;
    for (int i = 0; i < 74; i++) begin
      exp_ready = (i == 24) || (i == 49);
      if (ready_o != exp_ready) cnt++;
      chk($sformatf("held_ready_%0d", i), ready_o, exp_ready);
      if (i == 73) start_i = 1'b0;
      else @(negedge clk_i);
    end
    @(negedge clk_i);
    chk("held_final_ready", ready_o, 1);
    chk("held_quot", quot_o, 10);
    $display("held: pattern mismatches=%0d quot=%0h", cnt, quot_o);

    // Asynchronous reset in the middle of an operation.
    run_op(24'd5, 16'd0, lat);
    op_a_i  = 24'd1000;
    op_b_i  = 16'd7;
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (11) @(negedge clk_i);
    chk("midreset_busy", ready_o, 0);
    rst_i = 1'b1;
    #1;
    chk("midreset_ready", ready_o, 1);
    chk("midreset_quot", quot_o, 0);
    chk("midreset_rem", rem_o, 0);
    chk("midreset_dbz", dbz_o, 0);
    $display("midreset: ready=%0b quot=%0h rem=%0h dbz=%0b", ready_o, quot_o, rem_o, dbz_o);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    run_op(24'd1000, 16'd7, lat);
    chk("post_reset_quot", quot_o, 142);
    chk("post_reset_rem", rem_o, 6);
    chk("post_reset_latency", lat, 24);
    $display("post_reset: quot=%0h rem=%0h lat=%0d", quot_o, rem_o, lat);

    // Random operands checked against the division identity.
    for (int n = 0; n < 1000; n++) begin
      raw = $urandom;
      sa  = $signed(raw[23:0]);
      raw = $urandom;
      sb  = $signed(raw[15:0]) >>> $urandom_range(0, 15);
      if (sb == 0) sb = 16'sd3;
      if (sa == -24'sd8388608 && sb == -16'sd1) sb = 16'sd1;
      run_op(sa, sb, lat);
      aa = sa;
      bb = sb;
      qq = longint'($signed(quot_o));
      rr = longint'($signed(rem_o));
      chk("rnd_identity", qq * bb + rr, aa);
      chk("rnd_rem_mag", ((rr < 0 ? -rr : rr) < (bb < 0 ? -bb : bb)) ? 1 : 0, 1);
      chk("rnd_rem_sign", (rr == 0 || ((rr < 0) == (aa < 0))) ? 1 : 0, 1);
      chk("rnd_latency", lat, 24);
      $display("rnd%0d: a=%0d b=%0d -> quot=%0d rem=%0d", n, aa, bb, qq, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
